// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    localparam logic [1:0] LSU_FAULT_NONE     = 2'b00;
    localparam logic [1:0] LSU_FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] LSU_FAULT_ACCESS   = 2'b10;
    localparam logic [1:0] LSU_FAULT_FUNCT3   = 2'b11;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/lsu_addr_check.sv
// Effective-address adder and fault classifier (combinational).
// Misalignment trapping is present only when LSU_MISALIGN_TRAP_EN is defined.
module lsu_addr_check
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [31:0]           base,
    input  logic signed [11:0]    offset,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [1:0]            fault
);

    logic signed [31:0] off_sext;
    logic [31:0]        ea;
    logic               illegal;
    logic               out_of_range;
    logic               misaligned;

    assign off_sext = {{20{offset[11]}}, offset};
    assign ea       = base + $unsigned(off_sext);
    assign addr     = ea[ADDR_WIDTH-1:0];

    always_comb begin
        illegal = 1'b0;
        if (we) begin
            illegal = !(funct3 == SB || funct3 == SH || funct3 == SW);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // funct3[1:0] encodes access size for both loads and stores.
    assign misaligned = ((funct3[1:0] == 2'b01) && ea[0]) ||
                        ((funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign out_of_range = (ea[31:ADDR_WIDTH] != '0);

    always_comb begin
        fault = LSU_FAULT_NONE;
        if (illegal) begin
            fault = LSU_FAULT_FUNCT3;
        end else if (misaligned) begin
            fault = LSU_FAULT_MISALIGN;
        end else if (out_of_range) begin
            fault = LSU_FAULT_ACCESS;
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: MEM-stage request -> single-cycle memory strobe -> response.
// Build option: LSU_MISALIGN_TRAP_EN enables misalignment faults (handled in lsu_addr_check).
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_base,
    input  logic signed [11:0]    req_offset,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic [1:0]            resp_fault,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    lsu_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [1:0]            fault_p0;
    logic                  op_we_p1;
    logic                  accept;

    lsu_addr_check #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_check (
        .we     (req_we),
        .funct3 (req_funct3),
        .base   (req_base),
        .offset (req_offset),
        .addr   (addr_p0),
        .fault  (fault_p0)
    );

    assign accept = (state == ST_IDLE) && req_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes and handshakes decode from registered state only, so no req_* path reaches mem_*/resp_*.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = (fault_p0 != LSU_FAULT_NONE) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_ren   = !op_we_p1;
                mem_wen   = op_we_p1;
                state_nxt = op_we_p1 ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Stage p1: request fields captured at acceptance, held through ISSUE/WAIT/RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_we_p1   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_funct3 <= '0;
            resp_fault <= LSU_FAULT_NONE;
            resp_rdata <= '0;
        end else if (accept) begin
            op_we_p1   <= req_we;
            mem_addr   <= addr_p0;
            mem_wdata  <= req_wdata;
            mem_funct3 <= req_funct3;
            resp_fault <= fault_p0;
            resp_rdata <= '0;
        end else if (state == ST_WAIT) begin
            resp_rdata <= mem_rdata;
        end
    end

endmodule
